// File: rtl/id_ex_stage.sv
// Dual-issue ID/EX pipeline register with slot-2 load-use hazard detection and one-cycle bubble insertion.
// Optional bubble counter on stall_count is enabled by defining ID_EX_STALL_COUNT_EN.
module id_ex_stage #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rm_1,
    input  logic [REG_W-1:0] id_rd_11,
    input  logic [REG_W-1:0] id_rd_12,
    input  logic             id_alusrcb,
    input  logic             id_regwrite1,
    input  logic [REG_W-1:0] id_rm_2,
    input  logic [REG_W-1:0] id_rn_2,
    input  logic [REG_W-1:0] id_rd_2,
    input  logic             id_regwrite2,
    input  logic             id_memread2,
    input  logic             id_memwrite2,
    input  logic             flush,
    output logic [REG_W-1:0] ID_EX_rm_1,
    output logic [REG_W-1:0] ID_EX_rd_11,
    output logic [REG_W-1:0] ID_EX_rd_12,
    output logic [REG_W-1:0] ID_EX_rm_2,
    output logic [REG_W-1:0] ID_EX_rn_2,
    output logic [REG_W-1:0] ID_EX_rd_2,
    output logic             ID_EX_ALUSrcB,
    output logic             ID_EX_RegWrite1,
    output logic             ID_EX_RegWrite2,
    output logic             ID_EX_MemRead2,
    output logic             ID_EX_MemWrite2,
    output logic             ID_EX_valid,
`ifdef ID_EX_STALL_COUNT_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic             stall
);

    typedef enum logic {IDLE, BUBBLE} state_t;
    state_t state;

    logic [REG_W-1:0] src_b1;
    logic             hit_1;
    logic             hit_2;
    logic             hazard;

    // The load destination is compared only when non-zero, so r0 never matches.
    always_comb begin
        src_b1 = id_alusrcb ? id_rd_12 : id_rd_11;
        hit_1  = (ID_EX_rd_2 == id_rm_1) || (ID_EX_rd_2 == src_b1);
        hit_2  = (ID_EX_rd_2 == id_rm_2) || (ID_EX_rd_2 == id_rn_2) ||
                 (id_memwrite2 && (ID_EX_rd_2 == id_rd_2));
        hazard = ID_EX_valid && ID_EX_MemRead2 && (ID_EX_rd_2 != '0) &&
                 id_valid && (hit_1 || hit_2);
        stall  = !reset && !flush && (state == IDLE) && hazard;
    end

    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            ID_EX_rm_1      <= '0;
            ID_EX_rd_11     <= '0;
            ID_EX_rd_12     <= '0;
            ID_EX_rm_2      <= '0;
            ID_EX_rn_2      <= '0;
            ID_EX_rd_2      <= '0;
            ID_EX_ALUSrcB   <= 1'b0;
            ID_EX_RegWrite1 <= 1'b0;
            ID_EX_RegWrite2 <= 1'b0;
            ID_EX_MemRead2  <= 1'b0;
            ID_EX_MemWrite2 <= 1'b0;
            ID_EX_valid     <= 1'b0;
        end else begin
            ID_EX_rm_1      <= id_rm_1;
            ID_EX_rd_11     <= id_rd_11;
            ID_EX_rd_12     <= id_rd_12;
            ID_EX_rm_2      <= id_rm_2;
            ID_EX_rn_2      <= id_rn_2;
            ID_EX_rd_2      <= id_rd_2;
            ID_EX_ALUSrcB   <= id_alusrcb;
            ID_EX_RegWrite1 <= id_regwrite1;
            ID_EX_RegWrite2 <= id_regwrite2;
            ID_EX_MemRead2  <= id_memread2;
            ID_EX_MemWrite2 <= id_memwrite2;
            ID_EX_valid     <= id_valid;
        end

        if (reset || flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= stall ? BUBBLE : IDLE;
                BUBBLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    // stall is already low on flush and reset, so only hazard bubbles are counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage using immediate assertions.
module tb_id_ex_stage;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_alusrcb, id_regwrite1;
    logic [REG_W-1:0] id_rm_1, id_rd_11, id_rd_12, id_rm_2, id_rn_2, id_rd_2;
    logic id_regwrite2, id_memread2, id_memwrite2, flush;
    logic [REG_W-1:0] ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2;
    logic ID_EX_ALUSrcB, ID_EX_RegWrite1, ID_EX_RegWrite2, ID_EX_MemRead2, ID_EX_MemWrite2, ID_EX_valid;
    logic stall;
`ifdef ID_EX_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rm_1(id_rm_1), .id_rd_11(id_rd_11), .id_rd_12(id_rd_12),
        .id_alusrcb(id_alusrcb), .id_regwrite1(id_regwrite1),
        .id_rm_2(id_rm_2), .id_rn_2(id_rn_2), .id_rd_2(id_rd_2),
        .id_regwrite2(id_regwrite2), .id_memread2(id_memread2), .id_memwrite2(id_memwrite2),
        .flush(flush),
        .ID_EX_rm_1(ID_EX_rm_1), .ID_EX_rd_11(ID_EX_rd_11), .ID_EX_rd_12(ID_EX_rd_12),
        .ID_EX_rm_2(ID_EX_rm_2), .ID_EX_rn_2(ID_EX_rn_2), .ID_EX_rd_2(ID_EX_rd_2),
        .ID_EX_ALUSrcB(ID_EX_ALUSrcB), .ID_EX_RegWrite1(ID_EX_RegWrite1),
        .ID_EX_RegWrite2(ID_EX_RegWrite2), .ID_EX_MemRead2(ID_EX_MemRead2),
        .ID_EX_MemWrite2(ID_EX_MemWrite2), .ID_EX_valid(ID_EX_valid),
`ifdef ID_EX_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef ID_EX_STALL_COUNT_EN
        check(tag, 32'(stall_count), 32'(exp));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 1'b0; id_rm_1 = '0; id_rd_11 = '0; id_rd_12 = '0;
        id_alusrcb = 1'b0; id_regwrite1 = 1'b0; id_rm_2 = '0; id_rn_2 = '0;
        id_rd_2 = '0; id_regwrite2 = 1'b0; id_memread2 = 1'b0; id_memwrite2 = 1'b0;
    endtask

    // Drive a valid slot-2 load to rd and clock it into EX.
    task automatic push_load(input logic [REG_W-1:0] rd);
        clear_id();
        id_valid = 1'b1; id_memread2 = 1'b1; id_regwrite2 = 1'b1; id_rd_2 = rd;
        step();
    endtask

    function automatic logic [31:0] all_out();
        return {8'h0, ID_EX_rm_1, ID_EX_rd_11, ID_EX_rd_12, ID_EX_rm_2, ID_EX_rn_2, ID_EX_rd_2,
                ID_EX_ALUSrcB, ID_EX_RegWrite1, ID_EX_RegWrite2, ID_EX_MemRead2,
                ID_EX_MemWrite2, ID_EX_valid};
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; clear_id();
        @(negedge clk);
        // reset with random decode inputs
        id_valid = 1'b1; id_memread2 = 1'b1;
        id_rm_1 = REG_W'($urandom); id_rd_11 = REG_W'($urandom); id_rd_12 = REG_W'($urandom);
        id_rm_2 = REG_W'($urandom); id_rn_2 = REG_W'($urandom); id_rd_2 = REG_W'($urandom);
        id_alusrcb = 1'($urandom); id_regwrite1 = 1'b1; id_regwrite2 = 1'b1; id_memwrite2 = 1'b1;
        step(); step();
        check("reset_outputs", all_out(), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check_cnt("reset_count", 0);
        reset = 1'b0;

        // load-use on slot 1
        push_load(3'd3);
        check("ld_in_ex_memread", 32'(ID_EX_MemRead2), 32'h1);
        check("ld_in_ex_rd2", 32'(ID_EX_rd_2), 32'h3);
        clear_id(); id_valid = 1'b1; id_rm_1 = 3'd3; #1;
        check("lu1_stall", 32'(stall), 32'h1);
        step();
        check("lu1_bubble_valid", 32'(ID_EX_valid), 32'h0);
        check("lu1_bubble_rm1", 32'(ID_EX_rm_1), 32'h0);
        check("lu1_stall_drop", 32'(stall), 32'h0);
        step();
        check("lu1_pass_rm1", 32'(ID_EX_rm_1), 32'h3);
        check("lu1_pass_valid", 32'(ID_EX_valid), 32'h1);
        check_cnt("lu1_count", 1);

        // register 0 exemption
        push_load(3'd0);
        clear_id(); id_valid = 1'b1; id_rm_2 = 3'd0; id_rm_1 = 3'd6; #1;
        check("r0_stall", 32'(stall), 32'h0);
        step();
        check("r0_pass_rm1", 32'(ID_EX_rm_1), 32'h6);
        check("r0_pass_valid", 32'(ID_EX_valid), 32'h1);

        // store data hazard
        push_load(3'd5);
        clear_id(); id_valid = 1'b1; id_memwrite2 = 1'b1; id_rd_2 = 3'd5; #1;
        check("st_stall", 32'(stall), 32'h1);
        step();
        check("st_bubble_valid", 32'(ID_EX_valid), 32'h0);
        step();
        check("st_pass_memwrite", 32'(ID_EX_MemWrite2), 32'h1);
        check("st_pass_rd2", 32'(ID_EX_rd_2), 32'h5);
        check_cnt("st_count", 2);
        push_load(3'd5);
        clear_id(); id_valid = 1'b1; id_memwrite2 = 1'b0; id_rd_2 = 3'd5; #1;
        check("nost_stall", 32'(stall), 32'h0);
        step();

        // ALUSrcB selects which slot-1 field is a source
        push_load(3'd4);
        clear_id(); id_valid = 1'b1; id_rd_11 = 3'd4; id_rd_12 = 3'd2; id_alusrcb = 1'b1; #1;
        check("srcb1_stall", 32'(stall), 32'h0);
        step();
        check("srcb1_pass_alusrcb", 32'(ID_EX_ALUSrcB), 32'h1);
        push_load(3'd4);
        clear_id(); id_valid = 1'b1; id_rd_11 = 3'd4; id_rd_12 = 3'd2; id_alusrcb = 1'b0; #1;
        check("srcb0_stall", 32'(stall), 32'h1);
        step();
        check("srcb0_bubble_valid", 32'(ID_EX_valid), 32'h0);
        step();
        check("srcb0_pass_rd11", 32'(ID_EX_rd_11), 32'h4);
        check_cnt("srcb0_count", 3);

        // flush beats hazard
        push_load(3'd3);
        clear_id(); id_valid = 1'b1; id_rm_1 = 3'd3; flush = 1'b1; #1;
        check("flush_stall", 32'(stall), 32'h0);
        step();
        check("flush_bubble", all_out(), 32'h0);
        check_cnt("flush_count", 3);
        flush = 1'b0; #1;
        check("post_flush_stall", 32'(stall), 32'h0);
        step();
        check("post_flush_rm1", 32'(ID_EX_rm_1), 32'h3);
        check("post_flush_valid", 32'(ID_EX_valid), 32'h1);

        // reset while in BUBBLE
        push_load(3'd3);
        clear_id(); id_valid = 1'b1; id_rm_1 = 3'd3; #1;
        check("rb_stall", 32'(stall), 32'h1);
        step();
        reset = 1'b1; #1;
        check("rb_stall_in_reset", 32'(stall), 32'h0);
        step();
        check("rb_outputs", all_out(), 32'h0);
        check_cnt("rb_count", 0);
        reset = 1'b0; #1;
        check("rb_after_stall", 32'(stall), 32'h0);
        step();
        check("rb_after_valid", 32'(ID_EX_valid), 32'h1);
        check("rb_after_rm1", 32'(ID_EX_rm_1), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
